// File: rtl/eth_pkg.sv
// Shared types for the Ethernet RX frame filter: beat layout, drop causes, write FSM states.
package eth_pkg;

   localparam int unsigned ETH_DATA_W = 512;
   localparam int unsigned ETH_KEEP_W = 64;

   typedef struct packed {
      logic                  last;
      logic [ETH_KEEP_W-1:0] keep;
      logic [ETH_DATA_W-1:0] data;
   } eth_beat_t;

   typedef enum logic [1:0] {
      DropNone,
      DropErr,
      DropOvf,
      DropOversize
   } drop_cause_e;

   typedef enum logic {
      StIdle,
      StFrame
   } wr_state_e;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered, enable-held output.
module eth_sdp_ram #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned WIDTH = 577
) (
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_re,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WIDTH-1:0]         o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Output only changes on a read, so it doubles as the AXIS hold register.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/eth_rx_frame_filter.sv
// Store-and-forward RX frame buffer: frames are released only once complete and clean;
// errored, oversize or overflowing frames are discarded whole by rolling back the write pointer.
module eth_rx_frame_filter
   import eth_pkg::*;
#(
   parameter int unsigned DEPTH           = 64,
   parameter int unsigned MAX_FRAME_BEATS = 24
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  s_axis_rx_tvalid,
   output logic                  s_axis_rx_tready,
   input  logic [ETH_DATA_W-1:0] s_axis_rx_tdata,
   input  logic [ETH_KEEP_W-1:0] s_axis_rx_tkeep,
   input  logic                  s_axis_rx_tlast,
   input  logic                  s_axis_rx_tuser,
   output logic                  m_axis_rx_tvalid,
   input  logic                  m_axis_rx_tready,
   output logic [ETH_DATA_W-1:0] m_axis_rx_tdata,
   output logic [ETH_KEEP_W-1:0] m_axis_rx_tkeep,
   output logic                  m_axis_rx_tlast,
   output logic                  m_axis_rx_tuser,
   output logic [31:0]           stat_frames_ok,
   output logic [31:0]           stat_drop_err,
   output logic [31:0]           stat_drop_ovf,
   output logic [31:0]           stat_drop_oversize
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW = $clog2(MAX_FRAME_BEATS + 1);

   wr_state_e   r_state;
   wr_state_e   w_state_nxt;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_wr_commit;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] w_wr_ptr_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_base;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_err;
   logic          r_ovf;
   logic          r_oversize;
   logic          w_err_now;
   logic          w_ovf_now;
   logic          w_os_now;
   logic          w_in_beat;
   logic          w_full;
   logic          w_empty;
   logic          w_we;
   logic          w_re;
   logic          w_eof;
   drop_cause_e   w_cause;
   logic          r_out_valid;
   logic [31:0]   r_stat_ok;
   logic [31:0]   r_stat_err;
   logic [31:0]   r_stat_ovf;
   logic [31:0]   r_stat_os;
   eth_beat_t     w_wr_beat;
   eth_beat_t     w_rd_beat;

   // MAC side is never back-pressured; beats that cannot be stored mark the frame for drop.
   assign s_axis_rx_tready = 1'b1;
   assign w_in_beat        = s_axis_rx_tvalid;
   assign w_eof            = w_in_beat && s_axis_rx_tlast;

   assign w_full  = (r_wr_ptr - r_rd_ptr) == PW'(DEPTH);
   assign w_empty = (r_rd_ptr == r_wr_commit);

   // Write-side per-frame state; IDLE means this beat opens a fresh frame.
   always_comb begin
      w_cnt_base = '0;
      w_err_now  = s_axis_rx_tuser;
      w_ovf_now  = w_full;
      w_os_now   = 1'b0;
      if (r_state == StFrame) begin
         w_cnt_base = r_cnt;
         w_err_now  = r_err | s_axis_rx_tuser;
         w_ovf_now  = r_ovf | w_full;
      end
      w_os_now = ((r_state == StFrame) && r_oversize) || (w_cnt_base == CW'(MAX_FRAME_BEATS));
      w_we     = w_in_beat && !w_full && !((r_state == StFrame) && r_ovf) &&
                 (w_cnt_base < CW'(MAX_FRAME_BEATS));
      w_cnt_nxt = (w_cnt_base == CW'(MAX_FRAME_BEATS)) ? w_cnt_base : w_cnt_base + CW'(1);
      w_wr_ptr_nxt = w_we ? r_wr_ptr + PW'(1) : r_wr_ptr;
   end

   always_comb begin
      w_cause = DropNone;
      if (w_err_now) begin
         w_cause = DropErr;
      end else if (w_ovf_now) begin
         w_cause = DropOvf;
      end else if (w_os_now) begin
         w_cause = DropOversize;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_in_beat) begin
         w_state_nxt = s_axis_rx_tlast ? StIdle : StFrame;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_state     <= StIdle;
         r_wr_ptr    <= '0;
         r_wr_commit <= '0;
         r_cnt       <= '0;
         r_err       <= 1'b0;
         r_ovf       <= 1'b0;
         r_oversize  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_in_beat) begin
            if (s_axis_rx_tlast) begin
               r_cnt      <= '0;
               r_err      <= 1'b0;
               r_ovf      <= 1'b0;
               r_oversize <= 1'b0;
               if (w_cause == DropNone) begin
                  r_wr_ptr    <= w_wr_ptr_nxt;
                  r_wr_commit <= w_wr_ptr_nxt;
               end else begin
                  r_wr_ptr <= r_wr_commit;
               end
            end else begin
               r_cnt      <= w_cnt_nxt;
               r_err      <= w_err_now;
               r_ovf      <= w_ovf_now;
               r_oversize <= w_os_now;
               r_wr_ptr   <= w_wr_ptr_nxt;
            end
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_stat_ok  <= '0;
         r_stat_err <= '0;
         r_stat_ovf <= '0;
         r_stat_os  <= '0;
      end else if (w_eof) begin
         unique case (w_cause)
            DropNone:     r_stat_ok  <= sat_inc(r_stat_ok);
            DropErr:      r_stat_err <= sat_inc(r_stat_err);
            DropOvf:      r_stat_ovf <= sat_inc(r_stat_ovf);
            DropOversize: r_stat_os  <= sat_inc(r_stat_os);
         endcase
      end
   end

   // Prefetch from the committed region whenever the output slot is free or being drained.
   assign w_re = !w_empty && (!r_out_valid || m_axis_rx_tready);

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_rd_ptr    <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_re) begin
            r_rd_ptr    <= r_rd_ptr + PW'(1);
            r_out_valid <= 1'b1;
         end else if (m_axis_rx_tready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign w_wr_beat = '{last: s_axis_rx_tlast, keep: s_axis_rx_tkeep, data: s_axis_rx_tdata};

   eth_sdp_ram #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(eth_beat_t))
   ) u_ram (
      .i_clk   (ap_clk),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr[AW-1:0]),
      .i_wdata (w_wr_beat),
      .i_re    (w_re),
      .i_raddr (r_rd_ptr[AW-1:0]),
      .o_rdata (w_rd_beat)
   );

   // RAM output is not reset, so payload is masked to zero while no beat is held.
   assign m_axis_rx_tvalid   = r_out_valid;
   assign m_axis_rx_tdata    = r_out_valid ? w_rd_beat.data : '0;
   assign m_axis_rx_tkeep    = r_out_valid ? w_rd_beat.keep : '0;
   assign m_axis_rx_tlast    = r_out_valid & w_rd_beat.last;
   assign m_axis_rx_tuser    = 1'b0;
   assign stat_frames_ok     = r_stat_ok;
   assign stat_drop_err      = r_stat_err;
   assign stat_drop_ovf      = r_stat_ovf;
   assign stat_drop_oversize = r_stat_os;

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// Directed and random bench for eth_rx_frame_filter with a beat scoreboard.
module tb_eth_rx_frame_filter;
   import eth_pkg::*;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned MAXB  = 24;

   logic                  ap_clk = 1'b0;
   logic                  ap_rst;
   logic                  s_axis_rx_tvalid;
   logic                  s_axis_rx_tready;
   logic [ETH_DATA_W-1:0] s_axis_rx_tdata;
   logic [ETH_KEEP_W-1:0] s_axis_rx_tkeep;
   logic                  s_axis_rx_tlast;
   logic                  s_axis_rx_tuser;
   logic                  m_axis_rx_tvalid;
   logic                  m_axis_rx_tready;
   logic [ETH_DATA_W-1:0] m_axis_rx_tdata;
   logic [ETH_KEEP_W-1:0] m_axis_rx_tkeep;
   logic                  m_axis_rx_tlast;
   logic                  m_axis_rx_tuser;
   logic [31:0]           stat_frames_ok;
   logic [31:0]           stat_drop_err;
   logic [31:0]           stat_drop_ovf;
   logic [31:0]           stat_drop_oversize;

   always #5 ap_clk = ~ap_clk;

   eth_rx_frame_filter #(
      .DEPTH           (DEPTH),
      .MAX_FRAME_BEATS (MAXB)
   ) dut (
      .ap_clk             (ap_clk),
      .ap_rst             (ap_rst),
      .s_axis_rx_tvalid   (s_axis_rx_tvalid),
      .s_axis_rx_tready   (s_axis_rx_tready),
      .s_axis_rx_tdata    (s_axis_rx_tdata),
      .s_axis_rx_tkeep    (s_axis_rx_tkeep),
      .s_axis_rx_tlast    (s_axis_rx_tlast),
      .s_axis_rx_tuser    (s_axis_rx_tuser),
      .m_axis_rx_tvalid   (m_axis_rx_tvalid),
      .m_axis_rx_tready   (m_axis_rx_tready),
      .m_axis_rx_tdata    (m_axis_rx_tdata),
      .m_axis_rx_tkeep    (m_axis_rx_tkeep),
      .m_axis_rx_tlast    (m_axis_rx_tlast),
      .m_axis_rx_tuser    (m_axis_rx_tuser),
      .stat_frames_ok     (stat_frames_ok),
      .stat_drop_err      (stat_drop_err),
      .stat_drop_ovf      (stat_drop_ovf),
      .stat_drop_oversize (stat_drop_oversize)
   );

   int        n_checks = 0;
   int        n_pass   = 0;
   int        n_rx     = 0;
   int        exp_ok   = 0;
   int        exp_err  = 0;
   int        exp_ovf  = 0;
   int        exp_os   = 0;
   bit        rand_rdy = 1'b0;
   eth_beat_t sb[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_beat(input string tag, input eth_beat_t obs, input eth_beat_t exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check_stats(input string tag);
      check({tag, "_ok"}, 64'(stat_frames_ok), 64'(exp_ok));
      check({tag, "_err"}, 64'(stat_drop_err), 64'(exp_err));
      check({tag, "_ovf"}, 64'(stat_drop_ovf), 64'(exp_ovf));
      check({tag, "_os"}, 64'(stat_drop_oversize), 64'(exp_os));
   endtask

   // Output monitor: pops the scoreboard on every handshake and checks AXIS hold while stalled.
   eth_beat_t mon_beat;
   eth_beat_t stall_beat;
   bit        stalled = 1'b0;
   eth_beat_t exp_beat;

   always @(negedge ap_clk) begin
      mon_beat = {m_axis_rx_tlast, m_axis_rx_tkeep, m_axis_rx_tdata};
      if (ap_rst) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("hold_valid", 64'(m_axis_rx_tvalid), 64'd1);
            check_beat("hold_beat", mon_beat, stall_beat);
         end
         if (m_axis_rx_tvalid && m_axis_rx_tready) begin
            n_rx++;
            n_checks++;
            assert (sb.size() > 0) n_pass++;
            else $error("FAIL unexpected_beat: observed beat %h with nothing expected", mon_beat);
            if (sb.size() > 0) begin
               exp_beat = sb.pop_front();
               check_beat("beat", mon_beat, exp_beat);
            end
            check("tuser", 64'(m_axis_rx_tuser), 64'd0);
         end
         stalled    = m_axis_rx_tvalid && !m_axis_rx_tready;
         stall_beat = mon_beat;
      end
   end

   initial forever begin
      @(posedge ap_clk);
      #1;
      if (rand_rdy) m_axis_rx_tready = 1'($urandom_range(0, 1));
   end

   // Drives one frame back-to-back; err_beat is 1-based (0 = clean), will_ovf marks a predicted overflow.
   task automatic send_frame(input int len, input int err_beat, input bit will_ovf);
      eth_beat_t b;
      eth_beat_t pend[$];
      for (int i = 1; i <= len; i++) begin
         for (int w = 0; w < 16; w++) b.data[w*32 +: 32] = $urandom;
         b.last = (i == len);
         b.keep = b.last ? ({$urandom, $urandom} | 64'd1) : '1;
         s_axis_rx_tvalid = 1'b1;
         s_axis_rx_tdata  = b.data;
         s_axis_rx_tkeep  = b.keep;
         s_axis_rx_tlast  = b.last;
         s_axis_rx_tuser  = (i == err_beat);
         pend.push_back(b);
         @(posedge ap_clk);
         #1;
      end
      s_axis_rx_tvalid = 1'b0;
      s_axis_rx_tlast  = 1'b0;
      s_axis_rx_tuser  = 1'b0;
      if (err_beat != 0) exp_err++;
      else if (will_ovf) exp_ovf++;
      else if (len > int'(MAXB)) exp_os++;
      else begin
         exp_ok++;
         foreach (pend[k]) sb.push_back(pend[k]);
      end
   endtask

   task automatic wait_drain(input string tag);
      int i = 0;
      while ((sb.size() != 0 || m_axis_rx_tvalid) && i < 3000) begin
         @(posedge ap_clk);
         #1;
         i++;
      end
      check(tag, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   int rx0;
   int len;
   int eb;
   int guard;

   initial begin
      ap_rst           = 1'b1;
      s_axis_rx_tvalid = 1'b0;
      s_axis_rx_tdata  = '0;
      s_axis_rx_tkeep  = '0;
      s_axis_rx_tlast  = 1'b0;
      s_axis_rx_tuser  = 1'b0;
      m_axis_rx_tready = 1'b1;
      repeat (3) @(posedge ap_clk);
      #1;
      ap_rst = 1'b0;

      check("rst_tvalid", 64'(m_axis_rx_tvalid), 64'd0);
      check("rst_tlast", 64'(m_axis_rx_tlast), 64'd0);
      check("rst_tkeep", m_axis_rx_tkeep, 64'd0);
      check("rst_tdata_any", 64'(|m_axis_rx_tdata), 64'd0);
      check("rst_s_tready", 64'(s_axis_rx_tready), 64'd1);
      check_stats("rst");

      // 2-beat clean frame: latency N+2, two beats out
      rx0 = n_rx;
      send_frame(2, 0, 1'b0);
      check("t1_valid_n1", 64'(m_axis_rx_tvalid), 64'd0);
      @(posedge ap_clk);
      #1;
      check("t1_valid_n2", 64'(m_axis_rx_tvalid), 64'd1);
      wait_drain("t1_drain");
      check("t1_beats", 64'(n_rx - rx0), 64'd2);
      check_stats("t1");

      // Errored 3-beat frame then clean 1-beat frame
      rx0 = n_rx;
      send_frame(3, 2, 1'b0);
      send_frame(1, 0, 1'b0);
      wait_drain("t2_drain");
      check("t2_beats", 64'(n_rx - rx0), 64'd1);
      check_stats("t2");

      // Three 24-beat frames into a stalled output: the third overflows
      rx0 = n_rx;
      m_axis_rx_tready = 1'b0;
      send_frame(24, 0, 1'b0);
      send_frame(24, 0, 1'b0);
      send_frame(24, 0, 1'b1);
      repeat (4) @(posedge ap_clk);
      #1;
      check_stats("t3_stalled");
      check("t3_stall_valid", 64'(m_axis_rx_tvalid), 64'd1);
      m_axis_rx_tready = 1'b1;
      wait_drain("t3_drain");
      check("t3_beats", 64'(n_rx - rx0), 64'd48);

      // Oversize frame then maximum-length frame
      rx0 = n_rx;
      send_frame(25, 0, 1'b0);
      send_frame(24, 0, 1'b0);
      wait_drain("t4_drain");
      check("t4_beats", 64'(n_rx - rx0), 64'd24);
      check_stats("t4");

      // Random frames with random tuser and random downstream ready
      rand_rdy = 1'b1;
      for (int f = 0; f < 20; f++) begin
         len = $urandom_range(1, MAXB);
         eb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
         guard = 0;
         while (sb.size() + len > DEPTH && guard < 2000) begin
            @(posedge ap_clk);
            #1;
            guard++;
         end
         if (guard >= 2000) check("t5_space_timeout", 64'(sb.size()), 64'(DEPTH - len));
         send_frame(len, eb, 1'b0);
      end
      wait_drain("t5_drain");
      check_stats("t5");
      rand_rdy = 1'b0;
      @(posedge ap_clk);
      #2;
      m_axis_rx_tready = 1'b1;

      // Reset while a frame is streaming out
      send_frame(10, 0, 1'b0);
      repeat (3) @(posedge ap_clk);
      #1;
      ap_rst = 1'b1;
      @(posedge ap_clk);
      #1;
      ap_rst = 1'b0;
      sb.delete();
      exp_ok  = 0;
      exp_err = 0;
      exp_ovf = 0;
      exp_os  = 0;
      check("t6_valid_after_rst", 64'(m_axis_rx_tvalid), 64'd0);
      check_stats("t6_rst");
      rx0 = n_rx;
      send_frame(3, 0, 1'b0);
      wait_drain("t6_drain");
      check("t6_beats", 64'(n_rx - rx0), 64'd3);
      check_stats("t6");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
